// File: rtl/fetch_pkg.sv
// Shared constants and the entry type that flows from instruction memory to decode.
package fetch_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] FETCH_STRIDE = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        exc_adel;
  } fetch_entry_t;

  function automatic logic word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

  function automatic fetch_entry_t make_entry(input logic [31:0] pc,
                                              input logic [31:0] instruction,
                                              input logic        exc_adel);
    fetch_entry_t e;
    e.pc          = pc;
    e.instruction = instruction;
    e.exc_adel    = exc_adel;
    return e;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetch entries; the head slot is read straight from storage flops.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic             empty,
  output logic             full,
  output logic [OCC_W-1:0] occ
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [OCC_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == OCC_W'(DEPTH));
  assign occ     = count;
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & !empty;
  // A push into a full FIFO is only honoured when the head leaves in the same cycle.
  assign do_push = push & (!full | do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      count <= count + OCC_W'(do_push) - OCC_W'(do_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, credit-limited imem requests, in-order return
// buffering and redirect flushing ahead of decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_VECTOR,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc,
  output logic        id_exc_adel
);

  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int SUM_W = OCC_W + 1;

  logic [31:0]      pc_q;
  logic             halted;
  logic [OCC_W-1:0] outstanding;
  logic [OCC_W-1:0] outstanding_next;
  logic [OCC_W-1:0] discard;

  fetch_entry_t     buf_head;
  fetch_entry_t     buf_entry;
  logic             buf_empty;
  logic             buf_full;
  logic             buf_push;
  logic [OCC_W-1:0] buf_occ;

  fetch_entry_t     pcq_head;
  fetch_entry_t     pcq_entry;
  logic             pcq_empty;
  logic             pcq_full;
  logic [OCC_W-1:0] pcq_occ;

  logic             deq;
  logic [SUM_W-1:0] in_use;
  logic             credit_ok;
  logic             aligned;
  logic             issue;
  logic             dropping;
  logic             ret_push;
  logic             adel_push;
  logic             unused_bits;

  assign deq       = id_valid & id_ready;
  // Slots already promised: requests in flight plus buffered words, less the one leaving now.
  assign in_use    = SUM_W'(outstanding) + SUM_W'(buf_occ) - SUM_W'(deq);
  assign credit_ok = in_use < SUM_W'(BUF_DEPTH);
  assign aligned   = word_aligned(pc_q);

  assign imem_req  = reset_n & !halted & !redirect_valid & aligned & credit_ok;
  assign imem_addr = pc_q;
  assign issue     = imem_req & imem_gnt;

  assign dropping  = (discard != '0);
  assign ret_push  = imem_rvalid & !dropping & !redirect_valid;
  assign adel_push = !halted & !redirect_valid & !aligned & credit_ok;
  assign buf_push  = ret_push | adel_push;
  assign buf_entry = adel_push ? make_entry(pc_q, 32'h0, 1'b1)
                               : make_entry(pcq_head.pc, imem_rdata, 1'b0);
  assign pcq_entry = make_entry(pc_q, 32'h0, 1'b0);

  assign outstanding_next = outstanding + OCC_W'(issue) - OCC_W'(imem_rvalid);

  // Redirect wins: everything still in flight becomes discard, and fetching restarts at the target.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q        <= RESET_PC;
      halted      <= 1'b0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        pc_q    <= redirect_pc;
        halted  <= 1'b0;
        discard <= outstanding_next;
      end else begin
        if (issue) begin
          pc_q <= pc_q + FETCH_STRIDE;
        end
        if (adel_push) begin
          halted <= 1'b1;
        end
        if (imem_rvalid && dropping) begin
          discard <= discard - OCC_W'(1);
        end
      end
    end
  end

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_return_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect_valid),
    .push      (buf_push),
    .push_data (buf_entry),
    .pop       (deq),
    .head      (buf_head),
    .empty     (buf_empty),
    .full      (buf_full),
    .occ       (buf_occ)
  );

  // The PC queue tracks issued addresses only; it is never flushed so discarded returns still pop it.
  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_pc_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (1'b0),
    .push      (issue),
    .push_data (pcq_entry),
    .pop       (imem_rvalid),
    .head      (pcq_head),
    .empty     (pcq_empty),
    .full      (pcq_full),
    .occ       (pcq_occ)
  );

  assign id_valid       = !buf_empty;
  assign id_instruction = buf_head.instruction;
  assign id_pc          = buf_head.pc;
  assign id_exc_adel    = buf_head.exc_adel;

  assign unused_bits = ^{buf_full, pcq_empty, pcq_full, pcq_occ,
                         pcq_head.instruction, pcq_head.exc_adel};

  a_rvalid_expected: assert property (@(posedge clk) disable iff (!reset_n)
    imem_rvalid |-> (outstanding != '0));

  a_discard_bounded: assert property (@(posedge clk) disable iff (!reset_n)
    discard <= outstanding);

  a_credit_bounded: assert property (@(posedge clk) disable iff (!reset_n)
    (SUM_W'(outstanding) + SUM_W'(buf_occ)) <= SUM_W'(BUF_DEPTH));

  a_head_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (id_valid && !id_ready && !redirect_valid) |=>
      (id_valid && $stable(id_pc) && $stable(id_instruction)));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit: a PC-stream model per redirect segment.
module tb_fetch_unit;

  localparam logic [31:0] BOOT_PC = 32'hBFC0_0000;
  localparam int          DEPTH   = 2;
  localparam int          SEG_LEN = 256;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;
  logic        id_exc_adel;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(BOOT_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instruction (id_instruction),
    .id_pc          (id_pc),
    .id_exc_adel    (id_exc_adel)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        exc_adel;
  } expect_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } resp_t;

  expect_t     exp_q[$];
  resp_t       rsp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          cycle = 0;
  int          last_due = 0;
  int          gnt_pct = 100;
  int          ready_pct = 100;
  int          max_lat = 1;
  int          redir_pct = 0;
  bit          gap_pending = 1'b0;
  bit          prev_wait = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  bit          pending = 1'b0;
  logic [31:0] pending_pc = 32'h0;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    return {addr[15:0], addr[31:16]} ^ 32'hA5C3_0F1E;
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    int          sel;
    sel = int'($urandom_range(0, 9));
    t   = $urandom & 32'hFFFF_FFFC;
    if (sel == 0) t = t | 32'h2;
    else if (sel == 1) t = 32'hFFFF_FFF0;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %08h, expected %08h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Expected decode stream after fetching starts at 'start': consecutive words, or one address error.
  task automatic load_stream(input logic [31:0] start);
    logic [31:0] pc;
    exp_q.delete();
    if (start[1:0] != 2'b00) begin
      exp_q.push_back('{start, 32'h0, 1'b1});
    end else begin
      for (int i = 0; i < SEG_LEN; i++) begin
        pc = start + 32'(4 * i);
        exp_q.push_back('{pc, word_at(pc), 1'b0});
      end
    end
  endtask

  task automatic extend_stream();
    logic [31:0] pc;
    if (exp_q.size() != 0 && exp_q.size() < 16 && !exp_q[$].exc_adel) begin
      pc = exp_q[$].pc;
      for (int i = 0; i < 64; i++) begin
        pc = pc + 32'd4;
        exp_q.push_back('{pc, word_at(pc), 1'b0});
      end
    end
  endtask

  // One clock of stimulus: memory responses, grant, decode ready and an optional redirect.
  task automatic applyStimulus(input bit redir, input logic [31:0] target);
    resp_t r;
    @(posedge clk);
    #1;
    if (pending) begin
      load_stream(pending_pc);
      pending = 1'b0;
    end
    extend_stream();
    if (rsp_q.size() != 0 && rsp_q[0].due <= cycle) begin
      r = rsp_q.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = word_at(r.addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    imem_gnt       = (int'($urandom_range(0, 99)) < gnt_pct);
    id_ready       = (int'($urandom_range(0, 99)) < ready_pct);
    redirect_valid = redir;
    redirect_pc    = redir ? target : $urandom;
    if (redir) begin
      pending    = 1'b1;
      pending_pc = target;
    end
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      if (int'($urandom_range(0, 99)) < redir_pct) applyStimulus(1'b1, pick_target());
      else applyStimulus(1'b0, 32'h0);
    end
  endtask

  // Monitor: records granted requests for the memory model and scores every decode accept.
  always @(negedge clk) begin : monitor
    int      due;
    expect_t e;
    if (reset_n) begin
      if (gap_pending) check("gap_after_redirect", 32'(id_valid), 32'h0);
      gap_pending = redirect_valid;
      if (prev_wait && imem_req) check("addr_hold", imem_addr, prev_addr);
      prev_wait = imem_req & !imem_gnt;
      prev_addr = imem_addr;
      if (imem_req) check("req_aligned", 32'(imem_addr[1:0]), 32'h0);
      if (imem_req && imem_gnt) begin
        due = cycle + int'($urandom_range(1, max_lat));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        rsp_q.push_back('{imem_addr, due});
      end
      if (id_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_deq: got pc %08h, expected no instruction", id_pc);
        end else begin
          e = exp_q.pop_front();
          check("deq_pc", id_pc, e.pc);
          check("deq_instruction", id_instruction, e.instruction);
          check("deq_adel", 32'(id_exc_adel), 32'(e.exc_adel));
        end
      end
    end else begin
      gap_pending = 1'b0;
      prev_wait   = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] vld, input logic [31:0] pc,
                             input logic [31:0] req);
    check({tag, "_valid"}, 32'(id_valid), vld);
    if (vld != 0) check({tag, "_pc"}, id_pc, pc);
    check({tag, "_req"}, 32'(imem_req), req);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    check("rst_id_valid", 32'(id_valid), 32'h0);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_id_instruction", id_instruction, 32'h0);
    check("rst_id_adel", 32'(id_exc_adel), 32'h0);
    check("rst_imem_req", 32'(imem_req), 32'h0);
    check("rst_imem_addr", imem_addr, BOOT_PC);

    load_stream(BOOT_PC);
    imem_gnt = 1'b1;
    id_ready = 1'b1;
    reset_n  = 1'b1;
    @(negedge clk);
    check("boot_req", 32'(imem_req), 32'h1);
    check("boot_addr0", imem_addr, BOOT_PC);
    check("boot_valid0", 32'(id_valid), 32'h0);
    applyStimulus(1'b0, 32'h0);
    @(negedge clk);
    check("boot_addr1", imem_addr, BOOT_PC + 32'd4);
    check("boot_valid1", 32'(id_valid), 32'h0);
    applyStimulus(1'b0, 32'h0);
    @(negedge clk);
    checkOutput("boot_first", 32'h1, BOOT_PC, 32'h1);
    check("boot_addr2", imem_addr, BOOT_PC + 32'd8);

    ready_pct = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 32'h0);
      @(negedge clk);
      checkOutput("stall", 32'h1, BOOT_PC + 32'd4, 32'h0);
    end
    ready_pct = 100;
    random_run(20);

    max_lat = 3;
    random_run(4);
    applyStimulus(1'b1, 32'h8000_0100);
    random_run(25);

    applyStimulus(1'b1, 32'h8000_0102);
    random_run(15);
    check("adel_consumed", 32'(exp_q.size()), 32'h0);
    check("halted_no_req", 32'(imem_req), 32'h0);
    applyStimulus(1'b1, 32'h8000_0200);
    random_run(20);

    gnt_pct = 0;
    random_run(3);
    gnt_pct = 100;
    random_run(20);

    gnt_pct   = 70;
    ready_pct = 70;
    max_lat   = 4;
    redir_pct = 3;
    random_run(1500);

    redir_pct = 0;
    ready_pct = 100;
    gnt_pct   = 100;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      applyStimulus(1'b0, 32'h0);
      #1;
      seen = id_valid;
    end
    check("valid_before_reset", 32'(seen), 32'h1);
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(id_valid), 32'h0);
    check("async_rst_req", 32'(imem_req), 32'h0);
    check("async_rst_pc", id_pc, 32'h0);
    check("async_rst_instruction", id_instruction, 32'h0);
    rsp_q.delete();
    pending  = 1'b0;
    last_due = cycle;
    load_stream(BOOT_PC);
    applyStimulus(1'b0, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    check("restart_addr", imem_addr, BOOT_PC);

    gnt_pct   = 80;
    ready_pct = 60;
    redir_pct = 3;
    random_run(800);
    redir_pct = 0;
    ready_pct = 100;
    random_run(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
